layer_argmax: RTL and testbench



---
 rtl/layer_argmax_pkg.sv | 18 +
 rtl/argmax_compare.sv | 25 ++
 rtl/layer_argmax.sv | 193 +++++++++++++++++++
 tb/tb_layer_argmax.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_argmax_pkg.sv
// layer_argmax_pkg: shared types and defaults for the output-layer argmax.
package layer_argmax_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_SCAN,
    ST_OUT
  } state_t;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned IDX_W_DEF  = 4;

  // Class index reported when the watchdog fires; truncated to IDX_W at use.
  localparam logic [31:0] ERR_IDX = '1;

endpackage

// File: rtl/argmax_compare.sv
// argmax_compare: signed candidate-vs-running-max step; strict greater keeps
// the earlier (lower) index on ties.
module argmax_compare
  import layer_argmax_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF
) (
  input  logic [DATA_W-1:0] cand_i,
  input  logic [IDX_W-1:0]  cand_idx_i,
  input  logic [DATA_W-1:0] max_i,
  input  logic [IDX_W-1:0]  max_idx_i,
  output logic [DATA_W-1:0] max_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              replace_o
);

  // Pick the larger of candidate and running max.
  always_comb begin
    replace_o = $signed(cand_i) > $signed(max_i);
    max_o     = replace_o ? cand_i : max_i;
    idx_o     = replace_o ? cand_idx_i : max_idx_i;
  end

endmodule

// File: rtl/layer_argmax.sv
// layer_argmax: launches the perceptron bank, captures each activation on its
// done, runs a sequential signed argmax and offers the class on valid/ready.
// Optional watchdog: define LAYER_ARGMAX_TIMEOUT_EN.
module layer_argmax
  import layer_argmax_pkg::*;
#(
  parameter int unsigned N_NEURONS      = 10,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned IDX_W          = IDX_W_DEF,
  parameter int unsigned BLANK_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic                          start,
  output logic                          neuron_start,
  input  logic [N_NEURONS-1:0]          neuron_done,
  input  logic [N_NEURONS*DATA_W-1:0]   neuron_data,
  output logic [IDX_W-1:0]              class_tdata,
  output logic                          class_tvalid,
  input  logic                          class_tready,
  output logic [DATA_W-1:0]             max_value,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int unsigned BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  state_t                 state_q, state_d;
  logic                   start_q;
  logic                   start_edge;
  logic [N_NEURONS-1:0]   mask_q, mask_d;
  logic                   mask_full;
  logic [DATA_W-1:0]      cap_q [N_NEURONS];
  logic [DATA_W-1:0]      cap_d [N_NEURONS];
  logic [BLANK_W-1:0]     blank_q, blank_d;
  logic [IDX_W-1:0]       scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]      max_q, max_d;
  logic                   timeout_hit;
  logic [DATA_W-1:0]      cmp_max;
  logic [IDX_W-1:0]       cmp_idx;
  logic                   cmp_replace;

  assign start_edge = start & ~start_q;
  assign mask_full  = &mask_d;

  argmax_compare #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cmp (
    .cand_i     (cap_q[scan_idx_q]),
    .cand_idx_i (scan_idx_q),
    .max_i      (max_q),
    .max_idx_i  (idx_q),
    .max_o      (cmp_max),
    .idx_o      (cmp_idx),
    .replace_o  (cmp_replace)
  );

  // State register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // Next-state logic; WAIT exits on the cycle of the last capture.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_edge) state_d = ST_LAUNCH;
      ST_LAUNCH: if (blank_q == '0) state_d = ST_WAIT;
      ST_WAIT: begin
        if (mask_full)        state_d = ST_SCAN;
        else if (timeout_hit) state_d = ST_OUT;
      end
      ST_SCAN:   if (scan_idx_q == IDX_W'(N_NEURONS - 1)) state_d = ST_OUT;
      ST_OUT:    if (class_tready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    neuron_start = 1'b0;
    class_tvalid = 1'b0;
    busy         = 1'b1;
    unique case (state_q)
      ST_IDLE:           busy         = 1'b0;
      ST_LAUNCH, ST_WAIT: neuron_start = 1'b1;
      ST_OUT:            class_tvalid = 1'b1;
      default: ;
    endcase
  end

  assign class_tdata = idx_q;
  assign max_value   = max_q;

  // Capture: mask cleared in LAUNCH, each pending done latched once in WAIT.
  always_comb begin
    mask_d = mask_q;
    cap_d  = cap_q;
    if (state_q == ST_LAUNCH) begin
      mask_d = '0;
    end else if (state_q == ST_WAIT) begin
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        if (neuron_done[i] && !mask_q[i]) begin
          cap_d[i]  = neuron_data[i*DATA_W +: DATA_W];
          mask_d[i] = 1'b1;
        end
      end
    end
  end

  // Blanking counter and argmax scan datapath.
  always_comb begin
    blank_d    = blank_q;
    scan_idx_d = scan_idx_q;
    idx_d      = idx_q;
    max_d      = max_q;
    unique case (state_q)
      ST_IDLE:   if (start_edge) blank_d = BLANK_W'(BLANK_CYCLES - 1);
      ST_LAUNCH: if (blank_q != '0) blank_d = blank_q - 1'b1;
      ST_WAIT: begin
        // Seed from cap_d so a neuron-0 capture on the final cycle is seen.
        if (mask_full) begin
          max_d      = cap_d[0];
          idx_d      = '0;
          scan_idx_d = IDX_W'(1);
        end else if (timeout_hit) begin
          max_d = '0;
          idx_d = IDX_W'(ERR_IDX);
        end
      end
      ST_SCAN: begin
        if (cmp_replace) begin
          max_d = cmp_max;
          idx_d = cmp_idx;
        end
        scan_idx_d = scan_idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      start_q    <= 1'b0;
      mask_q     <= '0;
      blank_q    <= '0;
      scan_idx_q <= '0;
      idx_q      <= '0;
      max_q      <= '0;
      for (int unsigned i = 0; i < N_NEURONS; i++) cap_q[i] <= '0;
    end else begin
      start_q    <= start;
      mask_q     <= mask_d;
      blank_q    <= blank_d;
      scan_idx_q <= scan_idx_d;
      idx_q      <= idx_d;
      max_q      <= max_d;
      cap_q      <= cap_d;
    end
  end

`ifdef LAYER_ARGMAX_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_q;

  assign timeout_hit = (state_q == ST_WAIT) && !mask_full &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_q;

  // Watchdog: counts WAIT cycles; error flag sticky until the next launch.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == ST_WAIT) ? to_cnt_q + 1'b1 : '0;
      if (state_q == ST_IDLE && start_edge) timeout_q <= 1'b0;
      else if (timeout_hit)                 timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_layer_argmax.sv
// tb_layer_argmax: directed scoreboard bench for layer_argmax.
// Define LAYER_ARGMAX_TIMEOUT_EN to also exercise the watchdog.
module tb_layer_argmax;

  localparam int N     = 10;
  localparam int DW    = 32;
  localparam int IW    = 4;
  localparam int BLANK = 2;
`ifdef LAYER_ARGMAX_TIMEOUT_EN
  localparam int TO = 64;
`else
  localparam int TO = 4096;
`endif

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] val;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            neuron_start;
  logic [N-1:0]    done = '0;
  logic [N*DW-1:0] data = '0;
  logic [IW-1:0]   class_tdata;
  logic            class_tvalid;
  logic            tready = 1'b1;
  logic [DW-1:0]   max_value;
  logic            busy;
  logic            timeout_err;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t mon_e;

  layer_argmax #(
    .N_NEURONS      (N),
    .DATA_W         (DW),
    .IDX_W          (IW),
    .BLANK_CYCLES   (BLANK),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .start         (start),
    .neuron_start  (neuron_start),
    .neuron_done   (done),
    .neuron_data   (data),
    .class_tdata   (class_tdata),
    .class_tvalid  (class_tvalid),
    .class_tready  (tready),
    .max_value     (max_value),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Q5.27 encoding of an integer activation.
  function automatic logic [DW-1:0] q(input int v);
    return DW'(v * 134217728);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int v [N]);
    for (int i = 0; i < N; i++) data[i*DW +: DW] = q(v[i]);
  endtask

  task automatic expect_result(input int idx, input int v);
    exp_t e;
    e.idx = IW'(idx);
    e.val = q(v);
    sb.push_back(e);
  endtask

  // Pulse start; returns in the first WAIT cycle.
  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("neuron_start_rise", neuron_start, 1);
    repeat (BLANK) tick();
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    for (int k = 0; k < max_cycles && !class_tvalid; k++) tick();
    check(name, class_tvalid, 1);
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 20 && busy; k++) tick();
    check(name, busy, 0);
  endtask

  // Monitor: pop and compare on every accepted result.
  always @(negedge clk) begin
    if (rst_n && class_tvalid && tready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("class_tdata", class_tdata, mon_e.idx);
        check("max_value", max_value, mon_e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    // 17 lies outside the Q5.27 range [-16,16); 15 keeps the order and the tie.
    int v_ord   [N] = '{-5, 3, 15, 2, 9, 0, -1, 15, 4, 8};
    int ord     [N] = '{7, 3, 0, 9, 2, 5, 1, 8, 4, 6};
    int v_new   [N] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, -10};
    int v_zero  [N] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int v_neg   [N] = '{-9, -3, -7, -3, -4, -10, -16, -5, -6, -8};
    int v_rst   [N] = '{2, -1, 0, 15, -16, 3, 3, 14, 15, 1};

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_nstart", neuron_start, 0);
    check("rst_valid", class_tvalid, 0);
    check("rst_tdata", class_tdata, 0);
    check("rst_max", max_value, 0);
    check("rst_terr", timeout_err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Ordered, staggered dones; tie 2/7 resolves to 2
    set_data(v_ord);
    launch();
    expect_result(2, 15);
    for (int i = 0; i < N; i++) begin
      done[ord[i]] = 1'b1;
      tick();
      tick();
    end
    wait_valid("ordered_valid", 40);
    tick();
    wait_idle("ordered_idle");

    // Stale dones: old data, dones high through blanking, dropped in WAIT
    launch();
    done = '0;
    tick();
    check("no_stale_capture", neuron_start, 1);
    set_data(v_new);
    expect_result(8, 9);
    for (int i = 0; i < N; i++) begin
      done[i] = 1'b1;
      tick();
    end
    wait_valid("stale_valid", 40);
    tick();
    wait_idle("stale_idle");

    // Simultaneous dones, all zero; valid exactly N cycles later
    done = '0;
    set_data(v_zero);
    launch();
    expect_result(0, 0);
    done = '1;
    tick();
    check("simul_nstart_low", neuron_start, 0);
    repeat (N - 2) tick();
    check("simul_not_early", class_tvalid, 0);
    tick();
    check("simul_valid_at_N", class_tvalid, 1);
    tick();
    wait_idle("simul_idle");

    // Backpressure with all-negative data; start pulse in OUT ignored
    done = '0;
    tready = 1'b0;
    set_data(v_neg);
    launch();
    expect_result(1, -3);
    for (int i = N - 1; i >= 0; i--) begin
      done[i] = 1'b1;
      tick();
    end
    wait_valid("bp_valid", 40);
    for (int k = 0; k < 20; k++) begin
      check("bp_hold_valid", class_tvalid, 1);
      check("bp_hold_tdata", class_tdata, 1);
      check("bp_hold_max", max_value, q(-3));
      start = (k == 5);
      tick();
    end
    start = 1'b0;
    tready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("bp_start_ignored", busy, 0);
      tick();
    end

    // Reset in WAIT with 5 of 10 captured
    done = '0;
    set_data(v_rst);
    launch();
    for (int i = 0; i < 5; i++) begin
      done[i] = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_nstart", neuron_start, 0);
    check("mid_rst_valid", class_tvalid, 0);
    check("mid_rst_tdata", class_tdata, 0);
    check("mid_rst_max", max_value, 0);
    done = '0;
    tick();
    rst_n = 1'b1;
    tick();
    launch();
    expect_result(3, 15);
    for (int i = N - 1; i >= 0; i--) begin
      done[i] = 1'b1;
      tick();
    end
    wait_valid("post_rst_valid", 40);
    tick();
    wait_idle("post_rst_idle");

`ifdef LAYER_ARGMAX_TIMEOUT_EN
    // Watchdog: neuron 9 never completes
    done = '0;
    set_data(v_new);
    launch();
    expect_result(15, 0);
    for (int i = 0; i < N - 1; i++) begin
      done[i] = 1'b1;
      tick();
    end
    wait_valid("to_valid", 200);
    check("to_err_set", timeout_err, 1);
    tick();
    wait_idle("to_idle");
    check("to_err_sticky", timeout_err, 1);
    launch();
    check("to_err_cleared", timeout_err, 0);
    done = '0;
    tick();
    set_data('{0, 1, 2, 3, 4, 5, 6, 7, 8, 9});
    expect_result(9, 9);
    done = '1;
    wait_valid("to_next_valid", 40);
    tick();
    wait_idle("to_next_idle");
`endif

    repeat (3) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
